dtpu_out_stream_fifo: RTL

- Output buffer directly downstream of the dtpu core's output FIFO write port (WR_DATA / WR_EN / FULL_N).
- Absorbs 64-bit result words and re-emits them as an AXI4-Stream master toward the PS DMA.
- Frames the stream into packets of a programmed beat count, asserting TLAST on the final beat and pulsing frame_done.
- Sticky overflow flag and fill level for debug.

---
 rtl/dtpu_out_stream_fifo.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/dtpu_out_stream_fifo.sv
// Output buffer between the dtpu core's result write port and the PS DMA.
// Buffers result words and re-emits them as AXI4-Stream frames of a programmed beat count.
module dtpu_out_stream_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 16,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    aresetn,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    wr_en,
    output logic                    wr_full_n,
    input  logic                    frame_start,
    input  logic [LEN_WIDTH-1:0]    frame_len,
    input  logic                    flush,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic                    frame_done,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    overflow,
    input  logic                    clear_overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0]     wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]     rdPtr_q, rdPtr_d;
    logic [LVL_W-1:0]     level_q, level_d;
    logic [LEN_WIDTH-1:0] beatCnt_q, beatCnt_d;
    logic [LEN_WIDTH-1:0] frameLen_q, frameLen_d;
    logic [1:0]           state_q, state_d;
    logic                 overflow_q, overflow_d;

    logic isFull;
    logic isLastBeat;
    logic tvalid;
    logic rdHandshake;
    logic wrAccept;

    always_comb begin
        isFull      = (level_q == FULL_LVL);
        tvalid      = (state_q == ST_ACTIVE) && (level_q != '0);
        isLastBeat  = (beatCnt_q == frameLen_q - LEN_WIDTH'(1));
        rdHandshake = tvalid && m_axis_tready;
        // A write while full is dropped even if a read frees a slot this cycle.
        wrAccept    = wr_en && !isFull && !flush;
    end

    always_comb begin
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        level_d    = level_q;
        beatCnt_d  = beatCnt_q;
        frameLen_d = frameLen_q;
        state_d    = state_q;

        if (wr_en && isFull) begin
            overflow_d = 1'b1;
        end else if (clear_overflow) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end

        if (flush) begin
            wrPtr_d   = '0;
            rdPtr_d   = '0;
            level_d   = '0;
            beatCnt_d = '0;
            state_d   = ST_IDLE;
        end else begin
            if (wrAccept) begin
                wrPtr_d = wrPtr_q + PTR_W'(1);
            end
            if (rdHandshake) begin
                rdPtr_d = rdPtr_q + PTR_W'(1);
            end
            case ({wrAccept, rdHandshake})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase

            case (state_q)
                ST_IDLE: begin
                    if (frame_start && (frame_len != '0)) begin
                        frameLen_d = frame_len;
                        beatCnt_d  = '0;
                        state_d    = ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (rdHandshake) begin
                        beatCnt_d = beatCnt_q + LEN_WIDTH'(1);
                        if (isLastBeat) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    beatCnt_d = '0;
                    state_d   = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            level_q    <= '0;
            beatCnt_q  <= '0;
            frameLen_q <= '0;
            state_q    <= ST_IDLE;
            overflow_q <= 1'b0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            level_q    <= level_d;
            beatCnt_q  <= beatCnt_d;
            frameLen_q <= frameLen_d;
            state_q    <= state_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is cleared on reset so tdata reads back as zero until the first write.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wrAccept) begin
            mem[wrPtr_q] <= wr_data;
        end
    end

    assign wr_full_n     = !isFull;
    assign m_axis_tdata  = mem[rdPtr_q];
    assign m_axis_tvalid = tvalid;
    assign m_axis_tlast  = tvalid && isLastBeat;
    assign frame_done    = (state_q == ST_DONE) && !flush;
    assign level         = level_q;
    assign overflow      = overflow_q;

endmodule
